rs_wakeup_queue: RTL

Parametrised reservation station holding `rs_entry_t` entries between rename/dispatch and one functional unit. Operand-ready bits are woken from `N_WB` writeback buses, and the oldest fully-ready entry is issued under a valid/ready handshake. It generalises the fixed three-bus (ALU/LSU/BRU) writeback arrangement to any bus count and any depth. Age is tracked with an age matrix rather than ROB tags, so ROB wrap-around never affects select order.

---
 rtl/rs_wakeup_queue_pkg.sv | 39 +++
 rtl/rs_wakeup_queue_if.sv | 38 +++
 rtl/rs_age_select.sv | 58 +++++
 rtl/rs_wakeup_queue.sv | 119 +++++++++++
 4 files changed

// File: rtl/rs_wakeup_queue_pkg.sv
// rtl/rs_wakeup_queue_pkg.sv - shared sizes, entry/writeback types and wakeup-match helper
//
// Purpose: types shared by the reservation station, its age selector and the bench.
//   RS_DEPTH    default reservation-station depth
//   N_WB_PORTS  default number of writeback buses snooped for wakeup
//   rs_entry_t  dispatched micro-op with per-source ready bits
//   wb_pkt_t    writeback broadcast (valid / destination preg / destination used)
//   wb_hit()    1 when a writeback packet wakes the given physical register
package rs_wakeup_queue_pkg;

  localparam int RS_DEPTH   = 8;
  localparam int N_WB_PORTS = 3;
  localparam int PREG_W     = 6;
  localparam int ROB_W      = 5;
  localparam int OP_W       = 8;

  typedef struct packed {
    logic [ROB_W-1:0]  rob_tag;
    logic [OP_W-1:0]   op;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] prs1;
    logic              prs1_ready;
    logic [PREG_W-1:0] prs2;
    logic              prs2_ready;
  } rs_entry_t;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] prd;
    logic              rd_used;
  } wb_pkt_t;

  typedef wb_pkt_t wb_bus_t [N_WB_PORTS];

  function automatic logic wb_hit(wb_pkt_t pkt, logic [PREG_W-1:0] preg);
    return pkt.valid && pkt.rd_used && (pkt.prd == preg);
  endfunction

endpackage

// File: rtl/rs_wakeup_queue_if.sv
// rtl/rs_wakeup_queue_if.sv - dispatch, wakeup and issue bundle of the reservation station
//
// Purpose: groups every non-clock/reset signal of rs_wakeup_queue.
//   flush                       synchronous squash
//   in_valid/in_ready/in_entry  dispatch handshake
//   wb[N_WB]                    writeback buses snooped for wakeup
//   issue_valid/issue_ready/issue_entry  issue handshake toward the FU
//   occupancy                   count of resident entries
// Modports: master = dispatch/FU side, slave = the reservation station.
interface rs_wakeup_queue_if #(
  parameter int DEPTH = rs_wakeup_queue_pkg::RS_DEPTH,
  parameter int N_WB  = rs_wakeup_queue_pkg::N_WB_PORTS
);
  import rs_wakeup_queue_pkg::*;

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  rs_entry_t            in_entry;
  wb_pkt_t [N_WB-1:0]   wb;
  logic                 issue_valid;
  logic                 issue_ready;
  rs_entry_t            issue_entry;
  logic [OCC_W-1:0]     occupancy;

  modport master (
    output flush, in_valid, in_entry, wb, issue_ready,
    input  in_ready, issue_valid, issue_entry, occupancy
  );

  modport slave (
    input  flush, in_valid, in_entry, wb, issue_ready,
    output in_ready, issue_valid, issue_entry, occupancy
  );

endinterface

// File: rtl/rs_age_select.sv
// rtl/rs_age_select.sv - age matrix with oldest-ready one-hot select
//
// Purpose: tracks relative allocation order of DEPTH slots and picks the oldest
// ready one. Shared with the LSU queue.
//   clk, rst_n  clock, asynchronous active-low reset (matrix cleared)
//   valid       slots currently resident (before this cycle's allocation)
//   alloc_oh    one-hot slot allocated at this edge, or zero
//   ready       slots eligible for selection
//   grant       one-hot oldest ready slot, zero when none ready
module rs_age_select #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant
);

  // older[i][j] = 1 when slot i was allocated before slot j.
  logic [DEPTH-1:0] older   [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];
  logic [DEPTH-1:0] blocked;

  // A new entry is younger than everything resident: its row clears, its
  // column takes the current valid vector. Stale bits of free slots are
  // harmless because select only looks at ready (hence valid) rows.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) older_d[i] = older[i];
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_oh[i]) begin
        older_d[i] = '0;
        for (int j = 0; j < DEPTH; j++) older_d[j][i] = valid[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) older[i] <= older_d[i];
    end
  end

  // Slot i wins unless some other ready slot is older than it.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (ready[j] && older[j][i]) blocked[i] = 1'b1;
      end
    end
    grant = ready & ~blocked;
  end

endmodule

// File: rtl/rs_wakeup_queue.sv
// rtl/rs_wakeup_queue.sv - reservation station with writeback wakeup and oldest-ready issue
//
// Purpose: holds dispatched entries for one FU, wakes their source operands
// from N_WB writeback buses and issues the oldest fully-ready entry.
//   clk    clock
//   rst_n  asynchronous active-low reset, drops all entries immediately
//   bus    rs_wakeup_queue_if.slave: flush, dispatch (in_*), wb buses,
//          issue (issue_*), occupancy
module rs_wakeup_queue
  import rs_wakeup_queue_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int N_WB  = N_WB_PORTS
) (
  input  logic               clk,
  input  logic               rst_n,
  rs_wakeup_queue_if.slave   bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q;
  rs_entry_t        entries_q [DEPTH];
  rs_entry_t        entries_w [DEPTH];
  rs_entry_t        in_w;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] grant;
  logic [DEPTH-1:0] free_oh;
  logic [DEPTH-1:0] alloc_oh;
  logic [DEPTH-1:0] issue_oh;
  logic [OCC_W-1:0] occ;
  logic             do_alloc;
  logic             do_issue;

  // Wakeup: the incoming entry and every stored entry OR in any bus match.
  // Waking the incoming entry closes the window where its producer
  // broadcasts in the very cycle it is dispatched.
  always_comb begin
    in_w = bus.in_entry;
    for (int k = 0; k < N_WB; k++) begin
      if (wb_hit(bus.wb[k], bus.in_entry.prs1)) in_w.prs1_ready = 1'b1;
      if (wb_hit(bus.wb[k], bus.in_entry.prs2)) in_w.prs2_ready = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      entries_w[i] = entries_q[i];
      for (int k = 0; k < N_WB; k++) begin
        if (wb_hit(bus.wb[k], entries_q[i].prs1)) entries_w[i].prs1_ready = 1'b1;
        if (wb_hit(bus.wb[k], entries_q[i].prs2)) entries_w[i].prs2_ready = 1'b1;
      end
    end
  end

  // Readiness uses registered bits only, so a wakeup never issues same-cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = valid_q[i] && entries_q[i].prs1_ready && entries_q[i].prs2_ready;
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + OCC_W'(valid_q[i]);
  end

  // Descending scan so the lowest free index is the last one written.
  always_comb begin
    free_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
    end
  end

  rs_age_select #(.DEPTH(DEPTH)) u_age (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (valid_q),
    .alloc_oh (alloc_oh),
    .ready    (ready_vec),
    .grant    (grant)
  );

  assign bus.in_ready    = (occ != OCC_W'(DEPTH));
  assign bus.occupancy   = occ;
  assign bus.issue_valid = |ready_vec;

  assign do_alloc = bus.in_valid && bus.in_ready && !bus.flush;
  assign do_issue = bus.issue_valid && bus.issue_ready && !bus.flush;
  assign alloc_oh = do_alloc ? free_oh : '0;
  assign issue_oh = do_issue ? grant : '0;

  // Grant is one-hot, so the last match is the only match; slot 0 when idle.
  always_comb begin
    bus.issue_entry = entries_q[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) bus.issue_entry = entries_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (bus.flush) begin
      valid_q <= '0;
    end else begin
      valid_q <= (valid_q & ~issue_oh) | alloc_oh;
    end
  end

  // Payloads need no reset: they are only observed behind a valid bit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_q[i] <= alloc_oh[i] ? in_w : entries_w[i];
    end
  end

endmodule
